// File: rtl/riscv_mem_arb_pkg.sv
// Shared types for the fetch/data memory arbiter: FSM states, grant owner and
// the saturating streak increment used by the fairness logic.
package riscv_mem_arb_pkg;

  localparam int DATA_W   = 32;
  localparam int STREAK_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WAIT,
    RESP
  } state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_t;

  function automatic logic [STREAK_W-1:0] sat_inc(input logic [STREAK_W-1:0] v);
    return (v == '1) ? v : v + STREAK_W'(1);
  endfunction

endpackage

// File: rtl/riscv_mem_arbiter_if.sv
// Bus bundle between the pipeline requesters, the arbiter and the unified
// memory. slave is the arbiter's view; master is the requesters-plus-memory view.
interface riscv_mem_arbiter_if;
  import riscv_mem_arb_pkg::*;

  logic              i_req;
  logic [DATA_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;
  logic              d_rd;
  logic              d_wr;
  logic [DATA_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_re;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  i_req, i_addr, d_rd, d_wr, d_addr, d_wdata, mem_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, mem_addr, mem_wdata, mem_re, mem_we, busy
  );

  modport master (
    output i_req, i_addr, d_rd, d_wr, d_addr, d_wdata, mem_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, mem_addr, mem_wdata, mem_re, mem_we, busy
  );

endinterface

// File: rtl/riscv_mem_arb_select.sv
// Winner pick between fetch and data, with a saturating count of data grants
// that overtook a waiting fetch so the fetch is eventually forced through.
module riscv_mem_arb_select
  import riscv_mem_arb_pkg::*;
#(
  parameter int MAX_D_STREAK = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_req,
  input  logic   d_req,
  input  logic   grant,
  output owner_t winner
);

  logic [STREAK_W-1:0] streak_reg;
  logic [STREAK_W-1:0] streak_next;

  always_comb begin
    winner = OWN_I;
    if (d_req && !(i_req && streak_reg == STREAK_W'(MAX_D_STREAK))) begin
      winner = OWN_D;
    end
  end

  // Only data grants that actually made a fetch wait extend the streak.
  always_comb begin
    streak_next = streak_reg;
    if (grant) begin
      if (winner == OWN_D && i_req) begin
        streak_next = sat_inc(streak_reg);
      end else begin
        streak_next = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_reg <= '0;
    end else begin
      streak_reg <= streak_next;
    end
  end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Single-port memory arbiter for instruction fetch and load/store: one
// transaction at a time, fixed read latency, registered one-cycle acks.
module riscv_mem_arbiter
  import riscv_mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY  = 1,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  riscv_mem_arbiter_if.slave bus
);

  localparam logic [2:0] LAT_M1 = 3'(MEM_LATENCY - 1);

  state_t            state_reg,     state_next;
  owner_t            owner_reg,     owner_next;
  logic [2:0]        cnt_reg,       cnt_next;
  logic [DATA_W-1:0] mem_addr_reg,  mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
  logic              mem_re_reg,    mem_re_next;
  logic              mem_we_reg,    mem_we_next;
  logic              i_ack_reg,     i_ack_next;
  logic              d_ack_reg,     d_ack_next;
  logic [DATA_W-1:0] i_rdata_reg,   i_rdata_next;
  logic [DATA_W-1:0] d_rdata_reg,   d_rdata_next;
  logic              busy_reg,      busy_next;

  logic   d_req;
  logic   grant;
  owner_t winner;
  logic   capture;

  assign d_req = bus.d_rd | bus.d_wr;
  assign grant = (state_reg == IDLE) && (bus.i_req || d_req);

  riscv_mem_arb_select #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_select (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_req  (bus.i_req),
    .d_req  (d_req),
    .grant  (grant),
    .winner (winner)
  );

  // The latency counter is loaded on grant, so a read spends MEM_LATENCY-1
  // cycles in WAIT and mem_rdata is captured MEM_LATENCY edges after mem_re rose.
  always_comb begin
    state_next     = state_reg;
    owner_next     = owner_reg;
    cnt_next       = cnt_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    mem_re_next    = 1'b0;
    mem_we_next    = 1'b0;
    i_ack_next     = 1'b0;
    d_ack_next     = 1'b0;
    i_rdata_next   = i_rdata_reg;
    d_rdata_next   = d_rdata_reg;
    capture        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (grant) begin
          state_next = CMD;
          cnt_next   = LAT_M1;
          owner_next = winner;
          if (winner == OWN_D) begin
            mem_addr_next  = bus.d_addr;
            mem_wdata_next = bus.d_wdata;
            if (bus.d_wr) begin
              // Stores complete on the command cycle itself.
              mem_we_next = 1'b1;
              d_ack_next  = 1'b1;
            end else begin
              mem_re_next = 1'b1;
            end
          end else begin
            mem_addr_next = bus.i_addr;
            mem_re_next   = 1'b1;
          end
        end
      end
      CMD: begin
        if (mem_we_reg) begin
          state_next = IDLE;
        end else if (cnt_reg == 3'd0) begin
          capture = 1'b1;
        end else begin
          cnt_next   = cnt_reg - 3'd1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (cnt_reg == 3'd0) begin
          capture = 1'b1;
        end else begin
          cnt_next = cnt_reg - 3'd1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (capture) begin
      state_next = RESP;
      if (owner_reg == OWN_D) begin
        d_rdata_next = bus.mem_rdata;
        d_ack_next   = 1'b1;
      end else begin
        i_rdata_next = bus.mem_rdata;
        i_ack_next   = 1'b1;
      end
    end

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      owner_reg     <= OWN_I;
      cnt_reg       <= '0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_re_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      i_ack_reg     <= 1'b0;
      d_ack_reg     <= 1'b0;
      i_rdata_reg   <= '0;
      d_rdata_reg   <= '0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      cnt_reg       <= cnt_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      mem_re_reg    <= mem_re_next;
      mem_we_reg    <= mem_we_next;
      i_ack_reg     <= i_ack_next;
      d_ack_reg     <= d_ack_next;
      i_rdata_reg   <= i_rdata_next;
      d_rdata_reg   <= d_rdata_next;
      busy_reg      <= busy_next;
    end
  end

  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.mem_re    = mem_re_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.i_ack     = i_ack_reg;
  assign bus.d_ack     = d_ack_reg;
  assign bus.i_rdata   = i_rdata_reg;
  assign bus.d_rdata   = d_rdata_reg;
  assign bus.busy      = busy_reg;

endmodule
